serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-in, serial-out framed transmitter.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it onto a single-bit line as: start bit (0), data LSB first, stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks.
- Forms the driving end of the team's serial capture path, which samples the line with the flip-flop/shift-register receive chain.

Parameters:
- WIDTH, 8, data bits per frame (>=1).
- CLKS_PER_BIT, 4, clock cycles each bit is held on sout (>=1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- data_in  input  WIDTH  word to send; sampled only on an accepting edge.
- load  input  1  request to send data_in.
- ready  output  1  high when a load will be accepted.
- sout  output  1  serial line; idles high.
- busy  output  1  high while a frame is being sent.
- done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: rst=1 at a rising edge forces the following, regardless of state:
  - state=IDLE, sout=1, ready=1, busy=0, done=0;
  - bit counter, cycle counter and shift register cleared.
- Reset mid-frame aborts the frame immediately; no done pulse is produced.
- All outputs are registered. ready=1 iff state==IDLE; busy = !ready.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - sout=1.
  - On an edge with load=1 (ready is necessarily 1): latch data_in into the shift register, go to START, set sout=0, clear the cycle counter.
  - load=0: stay in IDLE.
- START: hold sout=0 for CLKS_PER_BIT cycles. At the last cycle, go to DATA and drive shift[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles.
  - At each bit boundary, shift right and advance the bit counter.
  - After bit WIDTH-1, go to STOP and set sout=1.
- STOP:
  - Hold sout=1 for CLKS_PER_BIT cycles.
  - At the last cycle, go to IDLE and pulse done=1 for exactly one cycle, coinciding with the first IDLE cycle (ready=1 that cycle).
- Timing:
  - Frame length is (WIDTH+2)*CLKS_PER_BIT cycles from the accepting edge to the edge that returns to IDLE.
  - sout changes only on bit boundaries.
  - Start bit is visible in the cycle after the accepting edge.
- load while busy: ignored, no queuing. data_in changes during a frame do not affect the frame.
- Back-to-back frames:
  - A load held high through done is accepted on the first IDLE edge.
  - The next start bit follows exactly one idle cycle (sout=1) after the stop bit.
- CLKS_PER_BIT=1: one cycle per bit, same state sequence.
- Counter widths: cycle counter spans CLKS_PER_BIT; bit counter spans WIDTH. No wrap-around occurs outside the defined states.

Test Plan:
- Reset: rst=1 for 2 edges, then rst=0 with load=0 for 10 cycles -> sout=1, ready=1, busy=0, done=0 throughout.
- Single frame, WIDTH=8, CLKS_PER_BIT=4, data_in=8'hA5, load pulsed 1 cycle:
  - sout bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles;
  - busy high 40 cycles; done pulses once, 40 cycles after the accepting edge.
- Ignore while busy: load=1 with data_in=8'h3C at cycle 10 of an 8'hA5 frame -> frame still carries A5; no second frame starts.
- Back-to-back: load held high with 8'hFF then 8'h00 -> the two frames are separated by exactly one sout=1 idle cycle; done pulses twice.
- Reset mid-frame: rst=1 during DATA bit 3 of 8'h5A -> the next cycle has sout=1, ready=1, busy=0 and no done pulse. A new frame with 8'h81 then transmits correctly.
- Edge parameters: CLKS_PER_BIT=1, WIDTH=4, data 4'b1001 -> sout 0,1,0,0,1,1 on consecutive cycles; done 6 cycles after acceptance.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start bit (0), WIDTH data bits LSB first, stop bit (1).
// Latency: start bit appears the cycle after an accepting edge; frame lasts (WIDTH+2)*CLKS_PER_BIT cycles.
// Backpressure: ready is low for the whole frame; a load while busy is dropped, never queued.
//
// Ports:
//   clk, rst      - single clock, synchronous active-high reset
//   data_in, load - word to send and its request; accepted when ready=1
//   ready, busy   - ready=1 only in IDLE; busy is its complement
//   sout          - serial line, idles high
//   done          - one-cycle pulse on the first IDLE cycle after a stop bit
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cyc_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             next_bit;
  logic             bit_end;

  // The bit driven after a shift is shift_reg[1]; a 1-bit word has no such bit.
  generate
    if (WIDTH > 1) begin : g_next_wide
      assign next_bit = shift_reg[1];
    end else begin : g_next_narrow
      assign next_bit = 1'b0;
    end
  endgenerate

  assign bit_end = (cyc_cnt == CYC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sout      <= 1'b1;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sout <= 1'b1;
          if (load) begin
            shift_reg <= data_in;
            state     <= START;
            sout      <= 1'b0;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            ready     <= 1'b0;
            busy      <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            sout    <= shift_reg[0];
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            cyc_cnt   <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == BIT_LAST) begin
              state <= STOP;
              sout  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sout    <= next_bit;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            state   <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          sout  <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: one 8-bit/4-clock instance and one 4-bit/1-clock instance.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected line values come from the frame definition: {0, data LSB first, 1}, each bit CPB cycles.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load, ready, sout, busy, done;
  logic [7:0] data_in;
  logic       rst_e, load_e, ready_e, sout_e, busy_e, done_e;
  logic [3:0] data_in_e;

  int checks   = 0;
  int failures = 0;

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .ready(ready), .sout(sout), .busy(busy), .done(done)
  );

  serial_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_e (
    .clk(clk), .rst(rst_e), .data_in(data_in_e), .load(load_e),
    .ready(ready_e), .sout(sout_e), .busy(busy_e), .done(done_e)
  );

  // Line value of frame bit k (0 = start, 1..width = data, width+1 = stop).
  function automatic logic exp_bit(input logic [31:0] d, input int width, input int k);
    if (k == 0) return 1'b0;
    if (k <= width) return d[k-1];
    return 1'b1;
  endfunction

  // Idle-state check of the main instance: sout=1 ready=1 busy=0 done=0.
  task automatic check_idle(input string name);
    checks++;
    if ({sout, ready, busy, done} !== 4'b1100) begin
      failures++;
      $display("FAIL %s: sout/ready/busy/done=%b%b%b%b expected 1100", name, sout, ready, busy, done);
    end
  endtask

  // Called at the falling edge just after acceptance; checks all 40 frame cycles.
  // intrude_at >= 0 raises load with 8'h3C at that cycle for two cycles.
  task automatic check_frame(input logic [7:0] d, input int intrude_at, input string name);
    for (int i = 0; i < 40; i++) begin
      logic e;
      e = exp_bit({24'd0, d}, 8, i / 4);
      checks++;
      if (sout !== e || busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s cycle=%0d: sout=%b busy=%b ready=%b done=%b expected sout=%b busy=1 ready=0 done=0",
                 name, i, sout, busy, ready, done, e);
      end
      if (i == intrude_at) begin
        load    = 1'b1;
        data_in = 8'h3C;
      end else if (intrude_at >= 0 && i == intrude_at + 2) begin
        load = 1'b0;
      end
      if (!load) data_in = 8'($urandom);
      @(negedge clk);
    end
  endtask

  // Cycle 40 after acceptance: first IDLE cycle with the done pulse.
  task automatic check_done(input string name);
    checks++;
    if ({sout, ready, busy, done} !== 4'b1101) begin
      failures++;
      $display("FAIL %s done cycle: sout/ready/busy/done=%b%b%b%b expected 1101", name, sout, ready, busy, done);
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    data_in = d;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_e = 1'b1; load = 1'b0; load_e = 1'b0;
    data_in = 8'h00; data_in_e = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; rst_e = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_idle("reset_idle");
      checks++;
      if ({sout_e, ready_e, busy_e, done_e} !== 4'b1100) begin
        failures++;
        $display("FAIL reset_idle_e: sout/ready/busy/done=%b%b%b%b expected 1100", sout_e, ready_e, busy_e, done_e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_frame();
    start_frame(8'hA5);
    check_frame(8'hA5, -1, "frame_a5");
    check_done("frame_a5");
    @(negedge clk);
    check_idle("frame_a5_after");
  endtask

  task automatic test_ignore_busy();
    start_frame(8'hA5);
    check_frame(8'hA5, 10, "ignore_busy");
    check_done("ignore_busy");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle("ignore_busy_no_second");
    end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 4; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      start_frame(d);
      check_frame(d, -1, "random_frame");
      check_done("random_frame");
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    data_in = 8'hFF;
    load    = 1'b1;
    @(negedge clk);
    data_in = 8'h00;
    check_frame(8'hFF, -1, "b2b_first");
    check_done("b2b_first");
    @(negedge clk);
    load = 1'b0;
    check_frame(8'h00, -1, "b2b_second");
    check_done("b2b_second");
    @(negedge clk);
    check_idle("b2b_after");
  endtask

  task automatic test_reset_mid_frame();
    int dones;
    start_frame(8'h5A);
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (sout !== exp_bit(32'h5A, 8, i / 4)) begin
        failures++;
        $display("FAIL mid_reset_prefix cycle=%0d: sout=%b expected %b", i, sout, exp_bit(32'h5A, 8, i / 4));
      end
      if (i == 17) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    check_idle("mid_reset_abort");
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL mid_reset_quiet: %0d cycles with done/busy set, expected 0", dones);
    end
    start_frame(8'h81);
    check_frame(8'h81, -1, "after_reset_81");
    check_done("after_reset_81");
    @(negedge clk);
  endtask

  task automatic test_edge_params();
    for (int n = 0; n < 4; n++) begin
      logic [3:0] d;
      d = (n == 0) ? 4'b1001 : 4'($urandom);
      data_in_e = d;
      load_e    = 1'b1;
      @(negedge clk);
      load_e    = 1'b0;
      data_in_e = 4'($urandom);
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (sout_e !== exp_bit({28'd0, d}, 4, i) || busy_e !== 1'b1 || done_e !== 1'b0) begin
          failures++;
          $display("FAIL edge_frame d=%b cycle=%0d: sout=%b busy=%b done=%b expected sout=%b busy=1 done=0",
                   d, i, sout_e, busy_e, done_e, exp_bit({28'd0, d}, 4, i));
        end
        @(negedge clk);
      end
      checks++;
      if ({sout_e, ready_e, busy_e, done_e} !== 4'b1101) begin
        failures++;
        $display("FAIL edge_done d=%b: sout/ready/busy/done=%b%b%b%b expected 1101", d, sout_e, ready_e, busy_e, done_e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ignore_busy();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
    test_edge_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
